inport_fifo: RTL and testbench
==============================

Name: inport_fifo

Overview:
- Buffered, parametrised input port for the CPU datapath. It replaces the single-register in-port.
- An external device pushes words through a strobe/ready handshake into a circular FIFO.
- The CPU reads the oldest word onto the bus during an "in" instruction: InPortout is asserted while Gra/Rin load the target register.
- The word is popped when InPortout deasserts, so a multi-cycle InPortout assertion always shows a stable value.

Parameters:
- DATA_W, 32, width of data words and bus.
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- PTR_W, log2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- ext_data  in  DATA_W  word presented by the external device.
- ext_strobe  in  1  device write request; sampled each rising edge.
- ext_ready  out  1  high when the FIFO can accept a word.
- InPortout  in  1  CPU read enable; drives the head word onto the bus.
- bus_out  out  DATA_W  bus driver contribution; zero when InPortout=0.
- count  out  PTR_W+1  number of stored words, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a push was rejected.
- underflow  out  1  sticky; a read completed while empty.
- clr_status  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (clr=1, asynchronous): wr_ptr, rd_ptr, count and rd_q (registered InPortout) go to 0. Outputs while in reset: bus_out=0, empty=1, full=0, ext_ready=1, overflow=0, underflow=0.
- Storage contents are not reset and are don't-care while empty.
- Reset mid-transfer discards all stored words and any pending pop. The first edge after clr falls behaves as post-reset.
- Combinational outputs:
  - bus_out = InPortout ? (empty ? 0 : mem[rd_ptr]) : 0.
  - ext_ready = !full.
- pop_evt = rd_q & !InPortout (falling edge of InPortout, detected one cycle after deassertion). rd_q <= InPortout every edge.
- Push: when ext_strobe=1 and (!full or pop_evt), write mem[wr_ptr] <= ext_data and increment wr_ptr modulo DEPTH.
- Rejected push: ext_strobe=1 while full with no pop_evt. Nothing is stored and overflow <= 1.
- Pop: when pop_evt and !empty, increment rd_ptr modulo DEPTH.
- Empty read: pop_evt with empty=1 sets underflow <= 1. Pointers are unchanged.
- Count update: +1 on push only, -1 on pop only. Unchanged on simultaneous push+pop, including when full; in that case the word is accepted and count stays DEPTH.
- Push into an empty FIFO appears on bus_out (if InPortout=1) from the next cycle. There is no bypass in the write cycle.
- One pop per InPortout assertion, regardless of its length. Holding InPortout for N cycles shows the same word for all N cycles.
- clr_status=1 clears both sticky flags at the edge. If a new overflow/underflow event occurs in the same cycle, set wins.
- Pointer wrap: wr_ptr/rd_ptr roll from DEPTH-1 to 0. Full and empty are distinguished by count, not pointer equality.

Test Plan:
- Reset and idle: assert clr for 2 cycles with ext_strobe=1.
  - Required: empty=1, count=0, ext_ready=1, bus_out=0.
  - Required: after clr falls, the first strobe is stored.
- Basic in-instruction: push 32'hFFFE93C5 (-93243) with DEPTH=4, then assert InPortout for 2 cycles.
  - Required: bus_out=32'hFFFE93C5 on both cycles.
  - Required: one cycle after deassert, count=0 and empty=1.
- Fill and overflow: push 1,2,3,4, then 5.
  - Required: full=1, ext_ready=0, overflow=1.
  - Required: four reads return 1,2,3,4; 5 is never seen.
- Wrap-around: push 6 words interleaved with 6 reads, keeping count ≤3.
  - Required: read order equals write order.
  - Required: pointers wrap past 3 with no corruption.
- Simultaneous push and pop when full: FIFO holds 1..4; the InPortout falling edge coincides with a push of 9.
  - Required: count stays 4, overflow stays 0.
  - Required: subsequent reads return 2,3,4,9.
- Underflow and status clear: assert then deassert InPortout while empty.
  - Required: bus_out=0, underflow=1, pointers unchanged.
  - Required: clr_status for 1 cycle returns underflow to 0.

Source files
------------

// File: rtl/inport_fifo.sv
// inport_fifo: buffered CPU input port.
// An external device pushes words through a strobe/ready handshake into a
// circular FIFO. During an "in" instruction the CPU asserts InPortout to
// drive the oldest word onto the bus. The word is popped when InPortout
// falls, so a multi-cycle read always shows a stable value.
module inport_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_strobe,
    output logic              ext_ready,
    input  logic              InPortout,
    output logic [DATA_W-1:0] bus_out,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_status
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Storage is not reset; its contents are don't-care while empty.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_q;

    logic pop_evt;
    logic push_ok;
    logic push_rej;
    logic pop_ok;
    logic pop_empty;

    // Status flags and handshake derived from the occupancy count.
    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        ext_ready = !full;
    end

    // Bus contribution: head word only while InPortout is high and data exists.
    always_comb begin
        bus_out = '0;
        if (InPortout && !empty) begin
            bus_out = mem[rd_ptr];
        end
    end

    // A pop is the falling edge of InPortout, seen one cycle after it drops.
    // A pop on a full FIFO frees a slot in the same edge, so the push is accepted.
    always_comb begin
        pop_evt   = rd_q && !InPortout;
        push_ok   = ext_strobe && (!full || pop_evt);
        push_rej  = ext_strobe && full && !pop_evt;
        pop_ok    = pop_evt && !empty;
        pop_empty = pop_evt && empty;
    end

    // Word storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ext_data;
        end
    end

    // Pointers, count and registered read enable.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= InPortout;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky error flags; a new event in the same cycle wins over clr_status.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_rej) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
            if (pop_empty) begin
                underflow <= 1'b1;
            end else if (clr_status) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inport_fifo.sv
// Self-checking bench for inport_fifo with a scoreboard queue of expected words.
module tb_inport_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk;
    logic              clr;
    logic [DATA_W-1:0] ext_data;
    logic              ext_strobe;
    logic              ext_ready;
    logic              InPortout;
    logic [DATA_W-1:0] bus_out;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              clr_status;

    int unsigned pass_cnt;
    int unsigned total_cnt;
    logic [DATA_W-1:0] exp_q [$];

    inport_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clr        (clr),
        .ext_data   (ext_data),
        .ext_strobe (ext_strobe),
        .ext_ready  (ext_ready),
        .InPortout  (InPortout),
        .bus_out    (bus_out),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow),
        .clr_status (clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word with the strobe for exactly one edge.
    task automatic push_word(input logic [DATA_W-1:0] d);
        ext_data   = d;
        ext_strobe = 1'b1;
        tick();
        ext_strobe = 1'b0;
    endtask

    // One in-instruction: InPortout high one cycle, sample bus, drop, let pop happen.
    task automatic read_word(output logic [DATA_W-1:0] d);
        InPortout = 1'b1;
        @(negedge clk);
        d = bus_out;
        tick();
        InPortout = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        clr        = 1'b1;
        ext_strobe = 1'b1;
        ext_data   = 32'hDEAD_BEEF;
        InPortout  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty);
        else pass_cnt++;
        total_cnt++;
        if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count);
        else pass_cnt++;
        total_cnt++;
        if (ext_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ext_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus_out !== 32'h0) $display("FAIL reset_bus: got %h expected 0", bus_out);
        else pass_cnt++;
        total_cnt++;
        if ({overflow, underflow, full} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {overflow, underflow, full});
        else pass_cnt++;
        // Release reset with the strobe still high: the first edge must store it.
        tick();
        InPortout = 1'b0;
        ext_data  = 32'h0000_00A5;
        clr       = 1'b0;
        tick();
        ext_strobe = 1'b0;
        exp_q.push_back(32'h0000_00A5);
        total_cnt++;
        if (count !== 3'd1) $display("FAIL post_reset_store: got count %0d expected 1", count);
        else pass_cnt++;
        read_word(d);
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL post_reset_read: scoreboard empty, got %h", d);
        else begin
            e = exp_q.pop_front();
            if (d !== e) $display("FAIL post_reset_read: got %h expected %h", d, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] e;
        push_word(32'hFFFE_93C5);
        exp_q.push_back(32'hFFFE_93C5);
        e = exp_q.pop_front();
        InPortout = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus_out !== e) $display("FAIL basic_bus_cycle%0d: got %h expected %h", c, bus_out, e);
            else pass_cnt++;
            tick();
        end
        InPortout = 1'b0;
        tick();
        total_cnt++;
        if (count !== 3'd0 || empty !== 1'b1)
            $display("FAIL basic_pop: got count %0d empty %b expected 0 1", count, empty);
        else pass_cnt++;
    endtask

    task automatic test_fill_overflow();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        for (int i = 1; i <= 4; i++) begin
            push_word(DATA_W'(i));
            exp_q.push_back(DATA_W'(i));
        end
        total_cnt++;
        if ({full, ext_ready, overflow} !== 3'b100 || count !== 3'd4)
            $display("FAIL fill_full: got full/ready/ovf %b count %0d expected 100 4",
                     {full, ext_ready, overflow}, count);
        else pass_cnt++;
        push_word(32'd5);
        total_cnt++;
        if (overflow !== 1'b1 || count !== 3'd4)
            $display("FAIL overflow_set: got ovf %b count %0d expected 1 4", overflow, count);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            read_word(d);
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL fill_read%0d: scoreboard empty, got %h", i, d);
            else begin
                e = exp_q.pop_front();
                if (d !== e) $display("FAIL fill_read%0d: got %h expected %h", i, d, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL fill_drained: got empty %b expected 1", empty);
        else pass_cnt++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", overflow);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        for (int i = 0; i < 6; i++) begin
            push_word(DATA_W'(32'h100 + i));
            exp_q.push_back(DATA_W'(32'h100 + i));
            if (i >= 2) begin
                total_cnt++;
                if (count !== 3'd3) $display("FAIL wrap_count%0d: got %0d expected 3", i, count);
                else pass_cnt++;
                read_word(d);
                total_cnt++;
                e = exp_q.pop_front();
                if (d !== e) $display("FAIL wrap_read%0d: got %h expected %h", i, d, e);
                else pass_cnt++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            read_word(d);
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL wrap_tail%0d: scoreboard empty, got %h", i, d);
            else begin
                e = exp_q.pop_front();
                if (d !== e) $display("FAIL wrap_tail%0d: got %h expected %h", i, d, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_simul_full();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        for (int i = 1; i <= 4; i++) begin
            push_word(DATA_W'(i));
            exp_q.push_back(DATA_W'(i));
        end
        InPortout = 1'b1;
        @(negedge clk);
        d = bus_out;
        tick();
        // Falling edge of InPortout and the push of 9 hit the same edge.
        InPortout  = 1'b0;
        ext_data   = 32'd9;
        ext_strobe = 1'b1;
        tick();
        ext_strobe = 1'b0;
        exp_q.push_back(32'd9);
        e = exp_q.pop_front();
        total_cnt++;
        if (d !== e) $display("FAIL simul_head: got %h expected %h", d, e);
        else pass_cnt++;
        total_cnt++;
        if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1)
            $display("FAIL simul_state: got count %0d ovf %b full %b expected 4 0 1",
                     count, overflow, full);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            read_word(d);
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL simul_read%0d: scoreboard empty, got %h", i, d);
            else begin
                e = exp_q.pop_front();
                if (d !== e) $display("FAIL simul_read%0d: got %h expected %h", i, d, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_underflow();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        read_word(d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL underflow_bus: got %h expected 0", d);
        else pass_cnt++;
        total_cnt++;
        if (underflow !== 1'b1 || count !== 3'd0 || empty !== 1'b1)
            $display("FAIL underflow_set: got unf %b count %0d empty %b expected 1 0 1",
                     underflow, count, empty);
        else pass_cnt++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total_cnt++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", underflow);
        else pass_cnt++;
        // Empty pop coinciding with clr_status: the new event wins.
        InPortout = 1'b1;
        tick();
        InPortout  = 1'b0;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total_cnt++;
        if (underflow !== 1'b1) $display("FAIL underflow_set_wins: got %b expected 1", underflow);
        else pass_cnt++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        // Pointers must still line up after the empty reads.
        push_word(32'h0000_0077);
        exp_q.push_back(32'h0000_0077);
        read_word(d);
        total_cnt++;
        e = exp_q.pop_front();
        if (d !== e || underflow !== 1'b0)
            $display("FAIL underflow_recover: got %h unf %b expected %h 0", d, underflow, e);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        clr        = 1'b1;
        ext_data   = '0;
        ext_strobe = 1'b0;
        InPortout  = 1'b0;
        clr_status = 1'b0;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_wrap();
        test_simul_full();
        test_underflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
